pipelined_shifter: RTL

Parametrised, fully pipelined barrel shifter with valid/ready handshakes at both ends. It supports logical left, logical right, arithmetic right and rotate right. It is the registered, multi-mode successor to the ALU's single-cycle 32-bit left shifter. It sits between operand issue and ALU writeback wherever shift latency may be traded for clock frequency.

---
 rtl/pipelined_shifter.sv | 115 +++++++++++
 1 files changed

// File: rtl/pipelined_shifter.sv
`default_nettype none
// pipelined_shifter: L-stage barrel shifter (SLL/SRL/SRA/ROR) with valid/ready at both ends.
// Revision: 1.0
module pipelined_shifter #(
    parameter  int WIDTH = 32,
    parameter  int TAG_W = 4,
    localparam int L     = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [L-1:0]     in_amt,
    input  logic [1:0]       in_op,
    input  logic             in_fill,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    logic             adv;
    logic             valid_q [L];
    logic [WIDTH-1:0] data_q  [L];
    logic [L-1:0]     amt_q   [L];
    logic [1:0]       op_q    [L];
    logic             fill_q  [L];
    logic             sign_q  [L];
    logic [TAG_W-1:0] tag_q   [L];

    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;
    assign out_valid = valid_q[L-1];
    assign out_data  = data_q[L-1];
    assign out_tag   = tag_q[L-1];
    assign out_zero  = ~|data_q[L-1];

    for (genvar k = 0; k < L; k++) begin : g_stage
        // Largest step first: stage k owns amount bit L-1-k.
        localparam int SH = 1 << (L - 1 - k);

        logic             w_valid;
        logic [WIDTH-1:0] w_src;
        logic [L-1:0]     w_amt;
        logic [1:0]       w_op;
        logic             w_fill;
        logic             w_sign;
        logic [TAG_W-1:0] w_tag;
        logic             w_vac;
        logic [WIDTH-1:0] w_shifted;
        logic [WIDTH-1:0] data_d;

        if (k == 0) begin : g_head
            assign w_valid = in_valid & adv;
            assign w_src   = in_data;
            assign w_amt   = in_amt;
            assign w_op    = in_op;
            assign w_fill  = in_fill;
            assign w_sign  = in_data[WIDTH-1];
            assign w_tag   = in_tag;
        end else begin : g_body
            assign w_valid = valid_q[k-1];
            assign w_src   = data_q[k-1];
            assign w_amt   = amt_q[k-1];
            assign w_op    = op_q[k-1];
            assign w_fill  = fill_q[k-1];
            assign w_sign  = sign_q[k-1];
            assign w_tag   = tag_q[k-1];
        end

        always_comb begin
            w_vac     = (w_op == OP_SRA) ? w_sign : w_fill;
            w_shifted = w_src;
            case (w_op)
                OP_SLL:  w_shifted = (w_src << SH) | (w_vac ? ~({WIDTH{1'b1}} << SH) : '0);
                OP_ROR:  w_shifted = (w_src >> SH) | (w_src << (WIDTH - SH));
                default: w_shifted = (w_src >> SH) | (w_vac ? ~({WIDTH{1'b1}} >> SH) : '0);
            endcase
            data_d = w_amt[L-1-k] ? w_shifted : w_src;
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                amt_q[k]   <= '0;
                op_q[k]    <= '0;
                fill_q[k]  <= 1'b0;
                sign_q[k]  <= 1'b0;
                tag_q[k]   <= '0;
            end else if (adv) begin
                valid_q[k] <= w_valid;
                data_q[k]  <= data_d;
                amt_q[k]   <= w_amt;
                op_q[k]    <= w_op;
                fill_q[k]  <= w_fill;
                sign_q[k]  <= w_sign;
                tag_q[k]   <= w_tag;
            end
        end
    end

    // Control fields of the last stage have no consumer.
    logic w_unused;
    assign w_unused = ^{amt_q[L-1], op_q[L-1], fill_q[L-1], sign_q[L-1]};

endmodule
`default_nettype wire
